// File: rtl/im_gray_conv.sv
// Streams N RGB words from image memory, converts to 8-bit luma, writes back in place.
// Optional IM_GRAY_THRESHOLD_EN binarises the luma against a threshold input.
module im_gray_conv #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] n_pixels,
    output logic              busy,
    output logic              done,
    output logic              r_en,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] r_data,
`ifdef IM_GRAY_THRESHOLD_EN
    input  logic [7:0]        threshold,
`endif
    output logic              w_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              r_en_q, r_en_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              done_q, done_d;
    logic              flush;

    logic              s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              w_en_q, w_en_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;

    logic [15:0]       sum;
    logic [7:0]        y;
    logic [DATA_W-1:0] pix;
    logic [DATA_W-16:0] unused_bits;

    always_comb begin
        state_d  = state_q;
        r_en_d   = 1'b0;
        r_addr_d = r_addr_q;
        last_d   = last_q;
        done_d   = 1'b0;
        flush    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_pixels != '0) begin
                        state_d  = READ;
                        r_en_d   = 1'b1;
                        r_addr_d = '0;
                        last_d   = n_pixels - ADDR_W'(1);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (r_addr_q == last_q) begin
                    state_d = DRAIN;
                end else begin
                    r_en_d   = 1'b1;
                    r_addr_d = r_addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (!s1_valid_q) begin
                    // last pixel is in the write stage this cycle
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sum = 16'd77  * {8'd0, r_data[23:16]}
            + 16'd150 * {8'd0, r_data[15:8]}
            + 16'd29  * {8'd0, r_data[7:0]};
        y   = sum[15:8];
`ifdef IM_GRAY_THRESHOLD_EN
        pix = (y >= threshold) ? DATA_W'(24'hFFFFFF) : '0;
`else
        pix = DATA_W'({y, y, y});
`endif
    end

    assign unused_bits = {sum[7:0], r_data[DATA_W-1:24]};

    always_comb begin
        s1_valid_d = r_en_q & ~flush;
        w_en_d     = s1_valid_q & ~flush;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        if (s1_valid_q) begin
            w_addr_d = s1_addr_q;
            w_data_d = pix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            r_en_q     <= 1'b0;
            r_addr_q   <= '0;
            last_q     <= '0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            w_en_q     <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            r_en_q     <= r_en_d;
            r_addr_q   <= r_addr_d;
            last_q     <= last_d;
            done_q     <= done_d;
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= r_addr_q;
            w_en_q     <= w_en_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign r_en   = r_en_q;
    assign r_addr = r_addr_q;
    assign w_en   = w_en_q;
    assign w_addr = w_addr_q;
    assign w_data = w_data_q;

endmodule

// File: doc/im_gray_conv.md
# im_gray_conv

Grayscale conversion engine that sits directly downstream of the image memory. On `start`, it streams `n_pixels` RGB words from the image memory read port. It converts each word to 8-bit luma and writes the result back through the image memory RAM write port at the same address. Throughput is one pixel per clock, with a fixed two-stage pipeline between read and write.

## Interface
- `DATA_W`, 32: pixel word width. Bits [23:16]=R, [15:8]=G, [7:0]=B; bits above 23 are ignored.
- `ADDR_W`, 19: pixel address width. Covers 640x480 = 307200 pixels.

- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  input  1  system clock; all logic on its rising edge.
  - `rst`  input  1  asynchronous, active-high reset.
- Control:
  - `start`  input  1  begin a conversion. Sampled only in IDLE.
  - `abort`  input  1  cancel the current conversion. Synchronous; ignored in IDLE.
  - `n_pixels`  input  ADDR_W  pixel count. Captured on the cycle `start` is accepted.
  - `busy`  output  1  high from the cycle after `start` is accepted through the last write.
  - `done`  output  1  one-cycle pulse when a conversion completes normally.
- Image memory read port:
  - `r_en`  output  1  read enable to the image memory.
  - `r_addr`  output  ADDR_W  read address.
  - `r_data`  input  DATA_W  read data, valid one cycle after `r_en`.
- Image memory RAM write port:
  - `w_en`  output  1  write enable to the RAM block.
  - `w_addr`  output  ADDR_W  write address.
  - `w_data`  output  DATA_W  converted pixel.
- Threshold (only when `IM_GRAY_THRESHOLD_EN` is defined):
  - `threshold`  input  8  binarisation level.

## Operation
- **FSM states:** IDLE, READ, DRAIN.
  - IDLE -> READ: `start`=1 and `n_pixels`!=0.
  - IDLE -> IDLE: `start`=1 and `n_pixels`=0. Pulses `done` the next cycle; no reads or writes are issued.
  - READ: issues `r_en`=1 with `r_addr`=0,1,…,N-1 on consecutive cycles. After the read of N-1 is issued, goes to DRAIN.
  - DRAIN: waits until the final write has been issued, then pulses `done` and goes to IDLE.
- **Conversion:** `sum` = 77·R + 150·G + 29·B, unsigned 16-bit (maximum 65280, no overflow). `Y` = `sum`[15:8]. Output word is {8'h00, Y, Y, Y}, zero-extended to DATA_W.
- **Pipeline:**
  - Stage 1 registers `r_addr` alongside the read.
  - Stage 2 registers `Y` and the address into the `w_*` outputs.
  - `w_addr` always equals the `r_addr` issued two cycles earlier.
- **start while busy:** ignored; `n_pixels` is not re-sampled.
- **abort:**
  - `r_en` drops the next cycle.
  - Every in-flight pixel is discarded; `w_en` stays low from the next cycle on.
  - FSM returns to IDLE; `busy` drops the next cycle; `done` is not pulsed.
- **Simultaneous abort and start in IDLE:** `start` wins, because `abort` is ignored in IDLE.
- **Addressing:** addresses never wrap. Maximum N = 2^ADDR_W−1, so the last address is 2^ADDR_W−2.
- **Reset, including mid-operation:** FSM goes to IDLE; pipeline valid bits are cleared.

## Timing
- Reset value of all outputs is 0: `busy`, `done`, `r_en`, `r_addr`, `w_en`, `w_addr`, `w_data`.
- Cycle numbering: `start` sampled high at cycle 0.
- Reads: `r_en`=1 on cycles 1..N, with `r_addr`=k on cycle k+1.
- Writes: `w_en`=1 on cycles 3..N+2, with `w_addr`=k on cycle k+3.
- `busy`: high on cycles 1..N+2.
- `done`: high on cycle N+3 only.
- Read-to-write latency is 2 cycles. Throughput is 1 pixel/cycle with no bubbles.
- A new `start` is accepted on cycle N+3 at the earliest.

## Configuration
- **Macro:** `IM_GRAY_THRESHOLD_EN`.
- **When defined:**
  - The `threshold` port exists.
  - Stage 2 compares `Y` >= `threshold`. The output is 0x00FFFFFF if true, else 0x00000000.
  - Latency is unchanged.
- **When undefined:**
  - There is no `threshold` port.
  - The output is the grayscale word {8'h00, Y, Y, Y}.

## Test plan
- **Single pixel:** memory[0]=0x00FF0000, `start` with `n_pixels`=1 -> one write at cycle 3 with `w_addr`=0 and `w_data`=0x004C4C4C. `done` at cycle 4.
- **Primaries and white:** 4 pixels 0x0000FF00, 0x000000FF, 0x00FFFFFF, 0xFF000000 -> writes 0x00959595, 0x001C1C1C, 0x00FFFFFF, 0x00000000. Writes on consecutive cycles 3..6; `done` at cycle 7.
- **Zero count:** `n_pixels`=0 -> no `r_en` and no `w_en`; `done`=1 at cycle 1; `busy` never rises.
- **Abort:** `n_pixels`=100, `abort` at cycle 10 -> `r_en`=0 and `w_en`=0 from cycle 11; last write is address 7; no `done`; a fresh `start` at cycle 12 is accepted.
- **Reset mid-operation:** `rst` pulsed at cycle 5 of a 50-pixel run -> all outputs 0 immediately; FSM in IDLE; `start` while busy before the reset is ignored.
- **Threshold build (`IM_GRAY_THRESHOLD_EN`):** `threshold`=128 with pixels 0x0000FF00 (Y=149) and 0x00FF0000 (Y=76) -> writes 0x00FFFFFF, 0x00000000.
